axi_lite_txn_scheduler: RTL and testbench

AXI_LITE_TXN_SCHEDULER -- requirements
Module: axi_lite_txn_scheduler

---
 rtl/axi_lite_txn_scheduler.sv | 150 +++++++++++++++
 tb/tb_axi_lite_txn_scheduler.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_txn_scheduler.sv
// Two-requester AXI4-Lite master: round-robin grant, one transaction in flight,
// single-cycle completion strobe with captured response/read data.
module axi_lite_txn_scheduler (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic [1:0]  req_ready,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        busy,
    output logic        AWVALID,
    input  logic        AWREADY,
    output logic [31:0] AWADDR,
    output logic        WVALID,
    input  logic        WREADY,
    output logic [31:0] WDATA,
    output logic [3:0]  WSTRB,
    input  logic        BVALID,
    output logic        BREADY,
    input  logic [1:0]  BRESP,
    output logic        ARVALID,
    input  logic        ARREADY,
    output logic [31:0] ARADDR,
    input  logic        RVALID,
    output logic        RREADY,
    input  logic [31:0] RDATA,
    input  logic [1:0]  RRESP
);
    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, RSP} state_t;

    state_t      r_state;
    logic        r_last_grant;
    logic        r_id;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
    logic        r_rsp_valid, r_rsp_id;
    logic [31:0] r_rsp_rdata;
    logic [1:0]  r_rsp_resp;

    logic        w_grant;
    logic        w_gnt_id;
    logic        w_aw_done;
    logic        w_w_done;

    // With both requesting, the one not served last time wins.
    assign w_gnt_id  = (req_valid == 2'b11) ? ~r_last_grant : req_valid[1];
    assign w_grant   = (r_state == IDLE) && (|req_valid);
    assign req_ready = w_grant ? (w_gnt_id ? 2'b10 : 2'b01) : 2'b00;

    // A write channel counts as done once its VALID has dropped or is handshaking now.
    assign w_aw_done = ~r_awvalid | AWREADY;
    assign w_w_done  = ~r_wvalid  | WREADY;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_resp   <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_last_grant <= w_gnt_id;
                        r_id         <= w_gnt_id;
                        r_addr       <= w_gnt_id ? req_addr[63:32]  : req_addr[31:0];
                        r_wdata      <= w_gnt_id ? req_wdata[63:32] : req_wdata[31:0];
                        if (req_write[w_gnt_id]) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= WR_ADDR;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= RD_ADDR;
                        end
                    end
                end
                WR_ADDR: begin
                    if (AWREADY) r_awvalid <= 1'b0;
                    if (WREADY)  r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (BVALID) begin
                        r_bready    <= 1'b0;
                        r_rsp_resp  <= BRESP;
                        r_rsp_rdata <= '0;
                        r_rsp_id    <= r_id;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RSP;
                    end
                end
                RD_ADDR: begin
                    if (ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (RVALID) begin
                        r_rready    <= 1'b0;
                        r_rsp_resp  <= RRESP;
                        r_rsp_rdata <= RDATA;
                        r_rsp_id    <= r_id;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RSP;
                    end
                end
                RSP:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_resp  = r_rsp_resp;
    assign AWVALID   = r_awvalid;
    assign AWADDR    = r_addr;
    assign WVALID    = r_wvalid;
    assign WDATA     = r_wdata;
    assign WSTRB     = 4'hF;
    assign BREADY    = r_bready;
    assign ARVALID   = r_arvalid;
    assign ARADDR    = r_addr;
    assign RREADY    = r_rready;
endmodule

// File: tb/tb_axi_lite_txn_scheduler.sv
// Directed bench for axi_lite_txn_scheduler: TB drives the AXI slave side by hand
// and compares every observation against hand-computed values.
module tb_axi_lite_txn_scheduler;
    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [1:0]  req_valid, req_write, req_ready;
    logic [63:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_id, busy;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;

    int n_cmp = 0;
    int n_err = 0;
    int cnt;

    always #5 ACLK = ~ACLK;

    axi_lite_txn_scheduler dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .busy(busy),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge ACLK);
        #1;
    endtask

    initial begin
        ARESETn = 1'b0;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
        ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;

        // reset state
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_rdy", req_ready, 0);
        chk("rst_rspv", rsp_valid, 0);
        chk("rst_awv", AWVALID, 0);
        chk("rst_arv", ARVALID, 0);
        chk("rst_addr", ARADDR, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_wstrb", WSTRB, 4'hF);
        @(posedge ACLK); @(posedge ACLK);
        tick();
        ARESETn = 1'b1;

        // single read, zero-wait slave
        req_valid = 2'b01; req_write = 2'b00; req_addr = {32'h0, 32'h11111111};
        ARREADY = 1; RVALID = 1; RDATA = 32'hCAFEF00D; RRESP = 2'b00;
        #1;
        chk("rd_gnt", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        chk("rd_arv", ARVALID, 1);
        chk("rd_araddr", ARADDR, 32'h11111111);
        chk("rd_busy", busy, 1);
        chk("rd_rdy0", req_ready, 0);
        tick();
        chk("rd_rready", RREADY, 1);
        chk("rd_arv_drop", ARVALID, 0);
        tick();
        chk("rd_rspv", rsp_valid, 1);
        chk("rd_id", rsp_id, 0);
        chk("rd_data", rsp_rdata, 32'hCAFEF00D);
        chk("rd_resp", rsp_resp, 0);
        tick();
        chk("rd_rspv_one", rsp_valid, 0);
        chk("rd_hold", rsp_rdata, 32'hCAFEF00D);
        chk("rd_idle", busy, 0);

        // write from requester 1, WREADY two cycles after AWREADY
        ARREADY = 0; RVALID = 0;
        req_valid = 2'b10; req_write = 2'b10;
        req_addr = {32'h20000004, 32'h0}; req_wdata = {32'h01010101, 32'h0};
        AWREADY = 1; WREADY = 0; BVALID = 1; BRESP = 2'b10;
        #1;
        chk("wr_gnt", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        chk("wr_awv", AWVALID, 1);
        chk("wr_wv", WVALID, 1);
        chk("wr_awaddr", AWADDR, 32'h20000004);
        chk("wr_wdata", WDATA, 32'h01010101);
        tick();
        AWREADY = 0;
        chk("wr_awv_drop", AWVALID, 0);
        chk("wr_wv_hold1", WVALID, 1);
        chk("wr_bready0", BREADY, 0);
        tick();
        chk("wr_wv_hold2", WVALID, 1);
        chk("wr_wdata_stb", WDATA, 32'h01010101);
        WREADY = 1;
        tick();
        WREADY = 0;
        chk("wr_wv_drop", WVALID, 0);
        chk("wr_bready", BREADY, 1);
        chk("wr_no_rsp", rsp_valid, 0);
        tick();
        chk("wr_rspv", rsp_valid, 1);
        chk("wr_id", rsp_id, 1);
        chk("wr_resp", rsp_resp, 2'b10);
        chk("wr_rdata", rsp_rdata, 0);
        tick();
        chk("wr_rspv_one", rsp_valid, 0);
        BVALID = 0;

        // both requesting continuously after reset: grants alternate 0,1,0,1
        ARESETn = 1'b0;
        req_valid = 2'b11; req_write = 2'b00;
        req_addr = {32'h33330001, 32'h33330000};
        ARREADY = 1; RVALID = 1; RDATA = 32'h12345678;
        tick();
        ARESETn = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            cnt = 0;
            while (req_ready == 2'b00 && cnt < 20) begin tick(); cnt++; end
            chk("rr_gnt", req_ready, k[0] ? 2'b10 : 2'b01);
            chk("rr_nobusy", busy, 0);
            cnt = 0;
            do begin tick(); cnt++; end while (!rsp_valid && cnt < 20);
            chk("rr_lat", cnt, 3);
            chk("rr_id", rsp_id, k[0]);
            chk("rr_rsp_nogrant", req_ready, 0);
            tick();
        end

        // ARREADY held off 10 cycles
        ARREADY = 0; RDATA = 32'hDEADBEEF;
        req_addr = {32'h5A5A0001, 32'hA5A50000};
        #1;
        chk("st_gnt", req_ready, 2'b01);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("st_arv", ARVALID, 1);
            chk("st_araddr", ARADDR, 32'hA5A50000);
            chk("st_busy", busy, 1);
            chk("st_rdy0", req_ready, 0);
        end
        ARREADY = 1;
        tick();
        req_valid = 2'b00;
        chk("st_rready", RREADY, 1);
        chk("st_arv_drop", ARVALID, 0);
        tick();
        chk("st_rspv", rsp_valid, 1);
        chk("st_data", rsp_rdata, 32'hDEADBEEF);
        tick();

        // reset during RD_DATA abandons the read
        RVALID = 0; req_valid = 2'b10;
        #1;
        chk("ab_gnt", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        chk("ab_arv", ARVALID, 1);
        tick();
        chk("ab_rready", RREADY, 1);
        #1 ARESETn = 1'b0;
        #1;
        chk("ab_rready0", RREADY, 0);
        chk("ab_busy0", busy, 0);
        chk("ab_rspv0", rsp_valid, 0);
        tick();
        RVALID = 1; req_valid = 2'b11;
        ARESETn = 1'b1;
        #1;
        chk("ab_rspv1", rsp_valid, 0);
        chk("ab_gnt0", req_ready, 2'b01);
        tick();
        chk("ab_rspv2", rsp_valid, 0);
        chk("ab_araddr", ARADDR, 32'hA5A50000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
